apb_target_decoder: RTL and testbench

APB_TARGET_DECODER -- requirements
Module: apb_target_decoder

---
 rtl/apb_pkg.sv | 35 +++
 rtl/apb_target_decoder_timeout.sv | 35 +++
 rtl/apb_target_decoder.sv | 179 +++++++++++++++++
 tb/tb_apb_target_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions: bus field widths, request/response bundles, the
// IDLE/ACCESS decoder state encoding and a saturating 8-bit increment.
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_t;

   typedef struct packed {
      logic [APB_ADDR_W-1:0] paddr;
      logic                  penable;
      logic                  psel;
      logic                  pwrite;
      logic [APB_DATA_W-1:0] pwdata;
   } apb_req_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] prdata;
      logic                  pready;
      logic                  perr;
   } apb_rsp_t;

   // Holds at 8'hFF instead of wrapping to zero.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/apb_target_decoder_timeout.sv
// -----------------------------------------------------------------------------
// apb_target_decoder_timeout
// Access-phase wait counter. Cleared at setup, advanced on each access cycle
// in which the selected target is still not ready.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_clr        : clear the counter (setup phase)
//   i_inc        : one more wait cycle observed
//   o_expired    : counter has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module apb_target_decoder_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int              CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // Stops at LAST; the decoder leaves ACCESS in that cycle anyway.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                     r_cnt <= '0;
      else if (i_clr)                   r_cnt <= '0;
      else if (i_inc && r_cnt != LAST)  r_cnt <= r_cnt + 1'b1;
   end

   assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/apb_target_decoder.sv
// -----------------------------------------------------------------------------
// apb_target_decoder
// Routes one upstream APB requester to NUM_TARGETS APB targets selected by
// paddr[SEL_LSB +: SEL_WIDTH]. Unmapped accesses and IDLE-phase protocol
// violations are answered locally with an error; err_count saturates at 255.
// Optional macro APB_TARGET_DECODER_TIMEOUT_EN adds an access-phase timeout of
// TIMEOUT_CYCLES cycles; without it ACCESS waits indefinitely.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   apb_request__*                    : upstream request
//   apb_response__*                   : upstream response
//   tgt_psel                          : one-hot target select
//   tgt_paddr/penable/pwrite/pwdata   : shared target request (paddr shifted)
//   tgt_prdata/pready/perr            : per-target responses, target i at [i*32 +: 32]
//   err_count                         : saturating error-response count
// -----------------------------------------------------------------------------
module apb_target_decoder
   import apb_pkg::*;
#(
   parameter int NUM_TARGETS    = 4,
   parameter int SEL_LSB        = 12,
   parameter int SEL_WIDTH      = 4,
   parameter int ADDR_SHIFT     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [APB_ADDR_W-1:0]             apb_request__paddr,
   input  logic                              apb_request__penable,
   input  logic                              apb_request__psel,
   input  logic                              apb_request__pwrite,
   input  logic [APB_DATA_W-1:0]             apb_request__pwdata,
   output logic [APB_DATA_W-1:0]             apb_response__prdata,
   output logic                              apb_response__pready,
   output logic                              apb_response__perr,
   output logic [NUM_TARGETS-1:0]            tgt_psel,
   output logic [APB_ADDR_W-1:0]             tgt_paddr,
   output logic                              tgt_penable,
   output logic                              tgt_pwrite,
   output logic [APB_DATA_W-1:0]             tgt_pwdata,
   input  logic [NUM_TARGETS*APB_DATA_W-1:0] tgt_prdata,
   input  logic [NUM_TARGETS-1:0]            tgt_pready,
   input  logic [NUM_TARGETS-1:0]            tgt_perr,
   output logic [7:0]                        err_count
);

   // One extra bit so NUM_TARGETS == 2**SEL_WIDTH still compares correctly.
   localparam logic [SEL_WIDTH:0] NUM_T = (SEL_WIDTH+1)'(NUM_TARGETS);

   apb_state_t           r_state, w_state_nxt;
   logic [SEL_WIDTH-1:0] r_sel_idx;
   logic                 r_mapped;
   logic [7:0]           r_err_count;

   apb_req_t               w_req;
   apb_rsp_t               w_tgt_rsp, w_rsp;
   logic [SEL_WIDTH-1:0]   w_dec_idx;
   logic                   w_dec_mapped;
   logic [NUM_TARGETS-1:0] w_dec_oh, w_sel_oh, w_psel;
   logic                   w_setup, w_err_inc, w_timeout;

   assign w_req = '{paddr:   apb_request__paddr,
                    penable: apb_request__penable,
                    psel:    apb_request__psel,
                    pwrite:  apb_request__pwrite,
                    pwdata:  apb_request__pwdata};

   assign w_dec_idx    = w_req.paddr[SEL_LSB +: SEL_WIDTH];
   assign w_dec_mapped = ({1'b0, w_dec_idx} < NUM_T);
   assign w_setup      = (r_state == IDLE) && w_req.psel && !w_req.penable;

   // Decoded one-hot (live paddr) and latched one-hot (sel_idx), plus the
   // response of the latched target.
   always_comb begin
      w_dec_oh  = '0;
      w_sel_oh  = '0;
      w_tgt_rsp = '0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         w_dec_oh[i] = w_dec_mapped && (w_dec_idx == SEL_WIDTH'(i));
         w_sel_oh[i] = r_mapped && (r_sel_idx == SEL_WIDTH'(i));
         if (w_sel_oh[i]) begin
            w_tgt_rsp.prdata = tgt_prdata[i*APB_DATA_W +: APB_DATA_W];
            w_tgt_rsp.pready = tgt_pready[i];
            w_tgt_rsp.perr   = tgt_perr[i];
         end
      end
   end

`ifdef APB_TARGET_DECODER_TIMEOUT_EN
   logic w_wait;
   assign w_wait = (r_state == ACCESS) && w_req.psel && r_mapped && !w_tgt_rsp.pready;

   apb_target_decoder_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clr     (w_setup),
      .i_inc     (w_wait),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_sel_idx   <= '0;
         r_mapped    <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_setup) begin
            r_sel_idx <= w_dec_idx;
            r_mapped  <= w_dec_mapped;
         end
         if (w_err_inc) r_err_count <= sat_inc8(r_err_count);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_psel      = '0;
      w_rsp       = '0;
      w_err_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req.psel && w_req.penable) begin
               // penable without a setup phase: refuse locally
               w_rsp.pready = 1'b1;
               w_rsp.perr   = 1'b1;
               w_err_inc    = 1'b1;
            end else if (w_req.psel) begin
               w_psel      = w_dec_oh;
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!w_req.psel) begin
               w_state_nxt = IDLE;               // master abort, silent
            end else if (!r_mapped) begin
               w_rsp.pready = 1'b1;
               w_rsp.perr   = 1'b1;
               w_err_inc    = 1'b1;
               w_state_nxt  = IDLE;
            end else if (w_tgt_rsp.pready) begin
               // Checked ahead of the timeout so a late target still wins.
               w_psel      = w_sel_oh;
               w_rsp       = w_tgt_rsp;
               w_state_nxt = IDLE;
            end else if (w_timeout) begin
               w_rsp.pready = 1'b1;
               w_rsp.perr   = 1'b1;
               w_err_inc    = 1'b1;
               w_state_nxt  = IDLE;
            end else begin
               w_psel = w_sel_oh;
               w_rsp  = w_tgt_rsp;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even if the master keeps
   // driving a request.
   assign tgt_psel             = reset_n ? w_psel : '0;
   assign apb_response__prdata = reset_n ? w_rsp.prdata : '0;
   assign apb_response__pready = reset_n & w_rsp.pready;
   assign apb_response__perr   = reset_n & w_rsp.perr;

   assign tgt_paddr   = w_req.paddr >> ADDR_SHIFT;
   assign tgt_penable = w_req.penable;
   assign tgt_pwrite  = w_req.pwrite;
   assign tgt_pwdata  = w_req.pwdata;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_apb_target_decoder.sv
`timescale 1ns/1ps
module tb_apb_target_decoder;

   localparam int NT = 4;
   localparam int TO = 16;
`ifdef APB_TARGET_DECODER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk;
   logic           reset_n;
   logic [31:0]    paddr;
   logic           penable, psel, pwrite;
   logic [31:0]    pwdata;
   logic [31:0]    rsp_prdata;
   logic           rsp_pready, rsp_perr;
   logic [NT-1:0]  tgt_psel;
   logic [31:0]    tgt_paddr;
   logic           tgt_penable, tgt_pwrite;
   logic [31:0]    tgt_pwdata;
   logic [NT*32-1:0] tgt_prdata;
   logic [NT-1:0]  tgt_pready, tgt_perr;
   logic [7:0]     err_count;

   apb_target_decoder #(
      .NUM_TARGETS(NT), .SEL_LSB(12), .SEL_WIDTH(4), .ADDR_SHIFT(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .apb_request__paddr   (paddr),
      .apb_request__penable (penable),
      .apb_request__psel    (psel),
      .apb_request__pwrite  (pwrite),
      .apb_request__pwdata  (pwdata),
      .apb_response__prdata (rsp_prdata),
      .apb_response__pready (rsp_pready),
      .apb_response__perr   (rsp_perr),
      .tgt_psel             (tgt_psel),
      .tgt_paddr            (tgt_paddr),
      .tgt_penable          (tgt_penable),
      .tgt_pwrite           (tgt_pwrite),
      .tgt_pwdata           (tgt_pwdata),
      .tgt_prdata           (tgt_prdata),
      .tgt_pready           (tgt_pready),
      .tgt_perr             (tgt_perr),
      .err_count            (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_err  = 0;   // expected err_count

   // One transfer: stimulus plus expected outcome. e_cyc is the access cycle
   // (1-based) in which pready must rise; 0 means no response within 100.
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          wait_n;
      logic [31:0] rdata;
      logic [3:0]  e_psel;
      logic [31:0] e_paddr;
      int          e_cyc;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int sat_add(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   // Reference: target from address bits [15:12], four targets mapped,
   // target answers after wait_n stall cycles, timeout fires on cycle TO.
   function automatic vec_t mk(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input int wait_n, input logic [31:0] rdata);
      vec_t v;
      int   idx;
      v.addr = addr; v.wr = wr; v.wdata = wdata; v.wait_n = wait_n; v.rdata = rdata;
      idx       = int'((addr / 4096) % 16);
      v.e_paddr = addr / 4;
      v.e_psel  = (idx < NT) ? 4'(1 << idx) : 4'b0;
      v.e_err   = 1'b0;
      v.e_rdata = 32'h0;
      if (idx >= NT) begin
         v.e_cyc = 1; v.e_err = 1'b1;
      end else if (TO_EN && wait_n >= TO) begin
         v.e_cyc = TO; v.e_err = 1'b1;
      end else if (wait_n >= 100) begin
         v.e_cyc = 0;
      end else begin
         v.e_cyc = wait_n + 1; v.e_rdata = rdata;
      end
      return v;
   endfunction

   task automatic quiet();
      tgt_pready = '1;
      tgt_prdata = '1;
      tgt_perr   = '0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   idx;
      int   k;
      bit   done;
      logic rdy;
      idx = int'(v.addr[15:12]);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.wr; pwdata = v.wdata;
      quiet();
      #1;
      chk({tag, ".setup_psel"},  32'(tgt_psel), 32'(v.e_psel));
      chk({tag, ".setup_paddr"}, tgt_paddr, v.e_paddr);
      chk({tag, ".setup_pwdata"}, tgt_pwdata, v.wdata);
      chk({tag, ".setup_pready"}, 32'(rsp_pready), 32'h0);
      @(posedge clk); #1;
      penable = 1'b1;
      k = 1; done = 1'b0;
      while (!done && k <= 100) begin
         for (int t = 0; t < NT; t++) begin
            if (t == idx) begin
               rdy = (k > v.wait_n);
               tgt_pready[t] = rdy;
               tgt_prdata[t*32 +: 32] = rdy ? v.rdata : $urandom;
               tgt_perr[t] = 1'b0;
            end else begin
               tgt_pready[t] = 1'($urandom);
               tgt_prdata[t*32 +: 32] = $urandom;
               tgt_perr[t] = 1'($urandom);
            end
         end
         #1;
         if (k == v.e_cyc) begin
            chk({tag, ".done_pready"}, 32'(rsp_pready), 32'h1);
            chk({tag, ".done_perr"},   32'(rsp_perr), 32'(v.e_err));
            chk({tag, ".done_prdata"}, rsp_prdata, v.e_rdata);
            chk({tag, ".done_psel"},   32'(tgt_psel), v.e_err ? 32'h0 : 32'(v.e_psel));
            done = 1'b1;
         end else begin
            chk({tag, ".wait_pready"}, 32'(rsp_pready), 32'h0);
            chk({tag, ".wait_psel"},   32'(tgt_psel), 32'(v.e_psel));
         end
         @(posedge clk); #1;
         k++;
      end
      psel = 1'b0; penable = 1'b0;
      quiet();
      if (v.e_err) m_err = sat_add(m_err);
      chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
   endtask

   task automatic viol(input logic [31:0] addr, input string tag);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b1; paddr = addr; pwrite = 1'b0;
      quiet();
      #1;
      chk({tag, ".pready"}, 32'(rsp_pready), 32'h1);
      chk({tag, ".perr"},   32'(rsp_perr), 32'h1);
      chk({tag, ".prdata"}, rsp_prdata, 32'h0);
      chk({tag, ".psel"},   32'(tgt_psel), 32'h0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      m_err = sat_add(m_err);
      chk({tag, ".err_count"}, 32'(err_count), 32'(m_err));
   endtask

   vec_t tbl[8];

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      // Fixed transfers with hand-derived expectations.
      tbl[0] = '{32'h0000_1008, 1'b1, 32'hDEADBEEF, 0,    32'h0,        4'b0010, 32'h402,  1,  1'b0, 32'h0};
      tbl[1] = '{32'h0000_3000, 1'b0, 32'h0,        3,    32'h12345678, 4'b1000, 32'hC00,  4,  1'b0, 32'h12345678};
      tbl[2] = '{32'h0000_5000, 1'b0, 32'h0,        0,    32'h0,        4'b0000, 32'h1400, 1,  1'b1, 32'h0};
      tbl[3] = '{32'h0000_0000, 1'b0, 32'h0,        1000, 32'h0,        4'b0001, 32'h0,    TO_EN ? 16 : 0, TO_EN, 32'h0};
      tbl[4] = '{32'h0000_2004, 1'b0, 32'h0,        2,    32'hA5A50F0F, 4'b0100, 32'h801,  3,  1'b0, 32'hA5A50F0F};
      tbl[5] = '{32'h0000_F00C, 1'b1, 32'h11111111, 0,    32'h0,        4'b0000, 32'h3C03, 1,  1'b1, 32'h0};
      tbl[6] = '{32'h0000_0010, 1'b0, 32'h0,        15,   32'h0BADF00D, 4'b0001, 32'h4,    16, 1'b0, 32'h0BADF00D};
      tbl[7] = '{32'h0000_1000, 1'b0, 32'h0,        14,   32'h76543210, 4'b0010, 32'h400,  15, 1'b0, 32'h76543210};

      // Reset held while the master drives a violation: outputs stay quiet.
      reset_n = 1'b0; psel = 1'b1; penable = 1'b1; paddr = 32'h1000; pwrite = 1'b0; pwdata = 32'h0;
      quiet();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.psel",      32'(tgt_psel), 32'h0);
      chk("rst.pready",    32'(rsp_pready), 32'h0);
      chk("rst.perr",      32'(rsp_perr), 32'h0);
      chk("rst.prdata",    rsp_prdata, 32'h0);
      chk("rst.err_count", 32'(err_count), 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      viol(32'h0000_1000, "viol");

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         ra[15:12] = 4'($urandom_range(0, 5));
         run_vec(mk(ra, 1'($urandom), $urandom, int'($urandom_range(0, 20)), $urandom),
                 $sformatf("rnd%0d", i));
      end

      // Reset asserted in the 2nd wait cycle of a target-2 access.
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_2000; pwrite = 1'b0;
      quiet();
      tgt_pready = '0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      chk("midrst.pre_psel",   32'(tgt_psel), 32'h4);
      chk("midrst.pre_pready", 32'(rsp_pready), 32'h0);
      reset_n = 1'b0;
      #1;
      m_err = 0;
      chk("midrst.psel",      32'(tgt_psel), 32'h0);
      chk("midrst.pready",    32'(rsp_pready), 32'h0);
      chk("midrst.prdata",    rsp_prdata, 32'h0);
      chk("midrst.err_count", 32'(err_count), 32'h0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; reset_n = 1'b1;
      quiet();
      run_vec(mk(32'h0000_2000, 1'b0, 32'h0, 1, 32'hCAFEF00D), "post_rst");

      // Saturation: 300 unmapped accesses.
      for (int i = 0; i < 300; i++) run_vec(tbl[2], "sat");
      chk("sat.final", 32'(err_count), 32'd255);
      viol(32'h0000_1000, "sat_viol");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
